imm_decode_stage: RTL and testbench
===================================

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (32 or 64 only).
REQ-002 SHALL have parameter CNT_W, default 16, width of the accepted-instruction counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-006 SHALL have port in_ready  output  1  stage can accept an instruction this cycle.
REQ-007 SHALL have port in_instr  input  32  RISC-V instruction word.
REQ-008 SHALL have port in_pc  input  XLEN  address of in_instr.
REQ-009 SHALL have port out_valid  output  1  registered result valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port out_imm  output  XLEN  sign-extended immediate.
REQ-012 SHALL have port out_fmt  output  3  format: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
REQ-013 SHALL have port out_target  output  XLEN  pc-relative target.
REQ-014 SHALL have port out_illegal  output  1  unsupported opcode flag.
REQ-015 SHALL have port acc_count  output  CNT_W  count of accepted instructions.

Function
REQ-016 SHALL drive in_ready = !out_valid || out_ready (combinational; one output register).
REQ-017 SHALL capture in_instr/in_pc on in_valid && in_ready; the result is valid on the next cycle (latency 1).
REQ-018 SHALL hold out_* stable while out_valid && !out_ready.
REQ-019 SHALL clear out_valid after out_valid && out_ready with no new capture; on simultaneous drain and capture, SHALL load the new result with out_valid staying 1 (full throughput).
REQ-020 SHALL decode opcodes: 0000011/0010011/1100111/1110011 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 0110011 -> R (imm 0); all others -> NONE (imm 0).
REQ-021 SHALL form I imm = sext(instr[31:20]); S = sext({instr[31:25],instr[11:7]}); B = sext({instr[31],instr[7],instr[30:25],instr[11:8],0}); J = sext({instr[31],instr[19:12],instr[20],instr[30:21],0}); U = sext({instr[31:12],12'b0}) to XLEN.
REQ-022 SHALL, for opcode 0010011 with funct3 001 or 101, output zero-extended shamt: instr[24:20] if XLEN=32, instr[25:20] if XLEN=64.
REQ-023 SHALL output out_target = in_pc + out_imm modulo 2^XLEN for B, J and AUIPC (0010111); 0 for all other opcodes.
REQ-024 SHALL increment acc_count by 1 per accepted instruction, wrapping from 2^CNT_W-1 to 0.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, set out_valid=0, out_imm=0, out_fmt=7, out_target=0, out_illegal=0, acc_count=0; in_ready=1 in the cycle after.
REQ-026 SHALL discard any held or in-flight result on rst asserted mid-operation; an instruction presented in a reset cycle SHALL not be counted.

Configuration
REQ-027 SHALL, with macro IMM_DECODE_ILLEGAL_EN defined, set out_illegal=1 for NONE-format opcodes, and for R-format when instr[31:25] is neither 0000000 nor 0100000.
REQ-028 SHALL, without IMM_DECODE_ILLEGAL_EN, tie out_illegal to 0; all other behaviour unchanged.

Verification
REQ-029 SHALL test: XLEN=32, in_instr 0xFE000EE3, in_pc 0x100 -> next cycle out_imm 0xFFFFFFFC, out_fmt 3, out_target 0x000000FC.
REQ-030 SHALL test: in_instr 0x0080006F (JAL), pc 0x2000 -> out_imm 8, fmt 5, target 0x2008; 0xFFF00093 -> imm 0xFFFFFFFF, fmt 1; 0x01F09093 (slli) -> imm 0x1F.
REQ-031 SHALL test: XLEN=64, in_instr 0x800002B7 (LUI) -> out_imm 0xFFFFFFFF80000000, fmt 4, target 0.
REQ-032 SHALL test: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* held, acc_count +1 only; out_ready=1 with back-to-back input -> one result per cycle.
REQ-033 SHALL test: in_instr 0x0000007F -> fmt 7, imm 0, out_illegal 1 with IMM_DECODE_ILLEGAL_EN, 0 without.
REQ-034 SHALL test: rst pulsed while out_valid=1 -> out_valid 0, acc_count 0; CNT_W=4 with 17 accepts -> acc_count 1.

Source files
------------

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: single-register RISC-V immediate decode stage.
// Captures an instruction on a valid/ready handshake, decodes its format and
// sign-extended immediate, forms the pc-relative target for branches, JAL and
// AUIPC, and counts accepted instructions. One output register gives full
// throughput: a held result drains and is replaced in the same cycle.
// Optional build macro IMM_DECODE_ILLEGAL_EN enables the out_illegal flag for
// unknown opcodes and R-format words with an unsupported funct7; without it
// out_illegal is tied low.

module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [XLEN-1:0]  out_target,
    output logic             out_illegal,
    output logic [CNT_W-1:0] acc_count
);

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [2:0]      dec_fmt;
    logic [31:0]     imm32;
    logic            dec_rel;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_target;
    logic            accept;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];

    // Decode format and a 32-bit immediate; every format fits in 32 bits
    // before the final sign extension to XLEN.
    always_comb begin
        dec_fmt     = FMT_NONE;
        imm32       = '0;
        dec_rel     = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            OP_LOAD, OP_JALR, OP_SYSTEM: begin
                dec_fmt = FMT_I;
                imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OP_IMM: begin
                dec_fmt = FMT_I;
                // Shifts carry an unsigned shamt, whose width follows XLEN.
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    if (XLEN == 64)
                        imm32 = {26'b0, in_instr[25:20]};
                    else
                        imm32 = {27'b0, in_instr[24:20]};
                end else begin
                    imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                end
            end
            OP_STORE: begin
                dec_fmt = FMT_S;
                imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OP_BRANCH: begin
                dec_fmt = FMT_B;
                dec_rel = 1'b1;
                imm32   = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0};
            end
            OP_LUI: begin
                dec_fmt = FMT_U;
                imm32   = {in_instr[31:12], 12'b0};
            end
            OP_AUIPC: begin
                dec_fmt = FMT_U;
                dec_rel = 1'b1;
                imm32   = {in_instr[31:12], 12'b0};
            end
            OP_JAL: begin
                dec_fmt = FMT_J;
                dec_rel = 1'b1;
                imm32   = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                           in_instr[30:21], 1'b0};
            end
            OP_REG: begin
                dec_fmt = FMT_R;
            end
            default: begin
                dec_fmt = FMT_NONE;
            end
        endcase
`ifdef IMM_DECODE_ILLEGAL_EN
        if (dec_fmt == FMT_NONE)
            dec_illegal = 1'b1;
        else if (opcode == OP_REG && in_instr[31:25] != 7'b0000000 &&
                 in_instr[31:25] != 7'b0100000)
            dec_illegal = 1'b1;
`else
        dec_illegal = 1'b0;
`endif
    end

    assign dec_imm    = XLEN'($signed(imm32));
    assign dec_target = dec_rel ? (in_pc + dec_imm) : '0;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Output register: load on accept, otherwise drop valid once drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_imm     <= '0;
            out_fmt     <= FMT_NONE;
            out_target  <= '0;
            out_illegal <= 1'b0;
            acc_count   <= '0;
        end else begin
            if (accept) begin
                out_valid   <= 1'b1;
                out_imm     <= dec_imm;
                out_fmt     <= dec_fmt;
                out_target  <= dec_target;
                out_illegal <= dec_illegal;
                acc_count   <= acc_count + CNT_W'(1);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: a 32-bit/16-bit-counter instance and a
// 64-bit/4-bit-counter instance share one stimulus stream. A behavioural
// model is checked on every cycle, and directed vectors pin literal values.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        out_ready;

    logic        rdy32, val32, ill32;
    logic [31:0] imm32, tgt32;
    logic [2:0]  fmt32;
    logic [15:0] cnt32;

    logic        rdy64, val64, ill64;
    logic [63:0] imm64, tgt64;
    logic [2:0]  fmt64;
    logic [3:0]  cnt64;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    // model state
    bit          mv;
    int          mcnt;
    logic [63:0] m_imm32, m_tgt32, m_imm64, m_tgt64;
    int          m_fmt;
    bit          m_ill;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .CNT_W(16)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(val32),
        .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
        .out_target(tgt32), .out_illegal(ill32), .acc_count(cnt32)
    );

    imm_decode_stage #(.XLEN(64), .CNT_W(4)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(val64),
        .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
        .out_target(tgt64), .out_illegal(ill64), .acc_count(cnt64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] wrap(input longint v, input int xlen);
        logic [63:0] r;
        r = 64'(v);
        if (xlen == 32) r = r & 64'h0000_0000_FFFF_FFFF;
        return r;
    endfunction

    // Immediate value as a plain signed integer, built field by field.
    function automatic void model_dec(input logic [31:0] ins, input logic [63:0] pc,
                                      input int xlen, output logic [63:0] imm,
                                      output int fmt, output logic [63:0] tgt,
                                      output bit ill);
        longint v;
        bit rel;
        logic [6:0] op;
        logic [2:0] f3;
        op = ins[6:0];
        f3 = ins[14:12];
        v = 0;
        rel = 0;
        ill = 0;
        case (op)
            7'b0000011, 7'b1100111, 7'b1110011, 7'b0010011: begin
                fmt = 1;
                if (op == 7'b0010011 && (f3 == 3'b001 || f3 == 3'b101)) begin
                    v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
                end else begin
                    v = longint'(ins[31:20]);
                    if (v >= 2048) v -= 4096;
                end
            end
            7'b0100011: begin
                fmt = 2;
                v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
                if (v >= 2048) v -= 4096;
            end
            7'b1100011: begin
                fmt = 3; rel = 1;
                v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                    longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                if (v >= 4096) v -= 8192;
            end
            7'b0110111, 7'b0010111: begin
                fmt = 4;
                rel = (op == 7'b0010111);
                v = longint'(ins[31:12]) * 4096;
                if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
            end
            7'b1101111: begin
                fmt = 5; rel = 1;
                v = longint'(ins[31]) * (1 << 20) + longint'(ins[19:12]) * 4096 +
                    longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                if (v >= (1 << 20)) v -= (1 << 21);
            end
            7'b0110011: begin
                fmt = 0;
`ifdef IMM_DECODE_ILLEGAL_EN
                ill = !(ins[31:25] == 7'h00 || ins[31:25] == 7'h20);
`endif
            end
            default: begin
                fmt = 7;
`ifdef IMM_DECODE_ILLEGAL_EN
                ill = 1;
`endif
            end
        endcase
        imm = wrap(v, xlen);
        tgt = rel ? wrap(longint'(pc) + v, xlen) : 64'd0;
    endfunction

    // Model: one result slot, refilled on each accepted handshake.
    always @(posedge clk) begin
        if (rst) begin
            mv = 0;
            mcnt = 0;
        end else if (in_valid && (!mv || out_ready)) begin
            model_dec(in_instr, {32'b0, in_pc[31:0]}, 32, m_imm32, m_fmt, m_tgt32, m_ill);
            model_dec(in_instr, in_pc, 64, m_imm64, m_fmt, m_tgt64, m_ill);
            mv = 1;
            mcnt++;
        end else if (mv && out_ready) begin
            mv = 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready32", rdy32, !mv || out_ready);
            chk("in_ready64", rdy64, !mv || out_ready);
            chk("valid32", val32, mv);
            chk("valid64", val64, mv);
            chk("count32", cnt32, mcnt % 65536);
            chk("count64", cnt64, mcnt % 16);
            if (mv) begin
                chk("imm32", imm32, m_imm32);
                chk("tgt32", tgt32, m_tgt32);
                chk("fmt32", fmt32, m_fmt);
                chk("ill32", ill32, m_ill);
                chk("imm64", imm64, m_imm64);
                chk("tgt64", tgt64, m_tgt64);
                chk("fmt64", fmt64, m_fmt);
                chk("ill64", ill64, m_ill);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [31:0] ins, input logic [63:0] pc);
        in_instr = ins;
        in_pc    = pc;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    logic [31:0] vecs [8] = '{32'h00112623, 32'h00001517, 32'h00B50533, 32'h02B50533,
                              32'h4030D093, 32'hFE112E23, 32'h80000063, 32'hFFDFF0EF};

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        step();
        started = 1'b1;
        step();
        chk("rst_valid", val32, 1'b0);
        chk("rst_fmt", fmt32, 3'd7);
        chk("rst_imm", imm64, 64'd0);
        chk("rst_tgt", tgt32, 32'd0);
        chk("rst_ill", ill64, 1'b0);
        chk("rst_cnt", cnt32, 16'd0);
        rst = 1'b0;
        step();
        chk("rst_ready", rdy32, 1'b1);

        apply(32'hFE000EE3, 64'h100);
        chk("beq_imm", imm32, 32'hFFFFFFFC);
        chk("beq_fmt", fmt32, 3'd3);
        chk("beq_tgt", tgt32, 32'h000000FC);
        chk("beq_imm64", imm64, 64'hFFFFFFFF_FFFFFFFC);
        apply(32'h0080006F, 64'h2000);
        chk("jal_imm", imm32, 32'd8);
        chk("jal_fmt", fmt32, 3'd5);
        chk("jal_tgt", tgt32, 32'h2008);
        apply(32'hFFF00093, 64'h0);
        chk("addi_imm", imm32, 32'hFFFFFFFF);
        chk("addi_fmt", fmt32, 3'd1);
        apply(32'h01F09093, 64'h0);
        chk("slli_imm", imm32, 32'h1F);
        chk("slli_imm64", imm64, 64'h1F);
        apply(32'h800002B7, 64'h40);
        chk("lui_imm64", imm64, 64'hFFFFFFFF_80000000);
        chk("lui_fmt64", fmt64, 3'd4);
        chk("lui_tgt64", tgt64, 64'd0);
        apply(32'h0000007F, 64'h0);
        chk("none_fmt", fmt32, 3'd7);
        chk("none_imm", imm32, 32'd0);
`ifdef IMM_DECODE_ILLEGAL_EN
        chk("none_ill", ill32, 1'b1);
`else
        chk("none_ill", ill32, 1'b0);
`endif
        foreach (vecs[i]) apply(vecs[i], 64'h400 + 64'(i * 4));
        step();

        // stall: downstream blocked for three cycles while input keeps coming
        out_ready = 1'b0;
        apply(32'h0080006F, 64'h3000);
        in_instr = 32'hFFF00093; in_pc = 64'h0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_ready", rdy32, 1'b0);
            chk("stall_hold", tgt32, 32'h3008);
        end
        out_ready = 1'b1;
        step();
        chk("drain_load", imm32, 32'hFFFFFFFF);
        for (int k = 0; k < 4; k++) begin
            in_instr = vecs[k];
            step();
            chk("b2b_valid", val32, 1'b1);
        end
        in_valid = 1'b0;
        step();

        // reset while a result is held and a new one is offered
        out_ready = 1'b0;
        apply(32'h00112623, 64'h0);
        in_valid = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        chk("midrst_valid", val32, 1'b0);
        chk("midrst_cnt", cnt32, 16'd0);
        out_ready = 1'b1;

        // 4-bit counter wrap
        in_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            in_instr = vecs[k % 8];
            step();
        end
        in_valid = 1'b0;
        step();
        chk("wrap_cnt64", cnt64, 4'd1);
        chk("wrap_cnt32", cnt32, 16'd17);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
